// File: rtl/seq_sort_extract.sv
// Sequential sort-and-extract block.
// Loads one vector of N unsigned WIDTH-bit elements, then streams them out one per transfer,
// extreme first (largest when DESCEND=1, smallest when DESCEND=0), ties going to the lowest
// original index. Each emitted element is removed from the live set.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (high only while idle)
//   in_data    packed vector, element i = in_data[i*WIDTH +: WIDTH]
//   out_valid  out_data/out_idx/out_last valid
//   out_ready  downstream accepts current output
//   out_data   selected element value
//   out_idx    original position of the selected element
//   out_last   high with the final element of the vector
module seq_sort_extract #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned N       = 4,
  parameter bit          DESCEND = 1'b1,
  parameter int unsigned IDXW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last
);

  localparam logic [IDXW:0] LastCnt = (IDXW + 1)'(N - 1);
  localparam logic [IDXW:0] CntOne  = (IDXW + 1)'(1);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] buf_q [N];
  logic [WIDTH-1:0] buf_d [N];
  logic [N-1:0]     mask_q, mask_d;
  logic [IDXW:0]    cnt_q, cnt_d;

  logic [IDXW-1:0]  sel;
  logic [WIDTH-1:0] best;
  logic             found;
  logic             last;

  // Linear scan over live elements. A strict compare means an equal value at a higher index
  // never displaces the current pick, which gives the stable lowest-index tie rule.
  always_comb begin
    sel   = '0;
    best  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask_q[i]) begin
        if (!found || (DESCEND ? (buf_q[i] > best) : (buf_q[i] < best))) begin
          sel   = IDXW'(i);
          best  = buf_q[i];
          found = 1'b1;
        end
      end
    end
  end

  assign last = (cnt_q == LastCnt);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int unsigned i = 0; i < N; i++) begin
            buf_d[i] = in_data[i*WIDTH +: WIDTH];
          end
          mask_d  = '1;
          cnt_d   = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        out_valid = 1'b1;
        out_data  = best;
        out_idx   = sel;
        out_last  = last;
        if (out_ready) begin
          mask_d[sel] = 1'b0;
          cnt_d       = cnt_q + CntOne;
          if (last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_seq_sort_extract.sv
// Self-checking bench for seq_sort_extract: a 4x16-bit descending instance (a_*) and an
// 8x8-bit ascending instance (b_*). A rank-based reference model gives the expected order.
module tb_seq_sort_extract;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [63:0] a_in_data;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_idx;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [63:0] b_in_data;
  logic [7:0]  b_out_data;
  logic [2:0]  b_out_idx;

  seq_sort_extract #(.WIDTH(16), .N(4), .DESCEND(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last)
  );

  seq_sort_extract #(.WIDTH(8), .N(8), .DESCEND(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitors: record every accepted vector and every emitted element.
  int qa_data[$], qa_idx[$], qa_last[$], qa_acc[$], qa_lcyc[$];
  int qb_data[$], qb_idx[$], qb_last[$], qb_acc[$];
  always @(posedge clk) begin
    if (rst_n) begin
      if (a_in_valid && a_in_ready) qa_acc.push_back(cyc);
      if (a_out_valid && a_out_ready) begin
        qa_data.push_back(int'(a_out_data));
        qa_idx.push_back(int'(a_out_idx));
        qa_last.push_back(int'(a_out_last));
        if (a_out_last) qa_lcyc.push_back(cyc);
      end
      if (b_in_valid && b_in_ready) qb_acc.push_back(cyc);
      if (b_out_valid && b_out_ready) begin
        qb_data.push_back(int'(b_out_data));
        qb_idx.push_back(int'(b_out_idx));
        qb_last.push_back(int'(b_out_last));
      end
    end
  end

  int vals[8];
  int ord[8];
  int held_bad;
  logic post_ready;

  // Expected emission order: element i goes to position rank(i), where rank counts the
  // elements that must precede it (better value, or equal value at a lower index).
  task automatic model(input int n, input bit desc);
    for (int i = 0; i < n; i++) begin
      int r = 0;
      for (int j = 0; j < n; j++) begin
        if ((desc ? (vals[j] > vals[i]) : (vals[j] < vals[i])) ||
            (vals[j] == vals[i] && j < i)) r++;
      end
      ord[r] = i;
    end
  endtask

  task automatic gen(input int n, input int maxv);
    int mode = int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       vals[i] = int'($urandom_range(0, maxv));
        1:       vals[i] = int'($urandom_range(0, 3));
        default: case ($urandom_range(0, 3))
                   0: vals[i] = 0;
                   1: vals[i] = 1;
                   2: vals[i] = maxv - 1;
                   default: vals[i] = maxv;
                 endcase
      endcase
    end
  endtask

  // Offers vals[0..3] to instance a and drains its 4 outputs; optional stall of stall_len
  // cycles on output number stall_at. Records stall violations in held_bad.
  task automatic collect_a(input int stall_at, input int stall_len, output int timeout);
    int base = qa_data.size();
    int abase = qa_acc.size();
    int guard = 0;
    bit stalled = 1'b0;
    logic [15:0] sd;
    logic [1:0] si;
    logic sl;
    timeout = 0;
    held_bad = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) a_in_data[i*16 +: 16] = 16'(vals[i]);
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    while (qa_data.size() < base + 4) begin
      @(negedge clk);
      guard++;
      if (a_in_valid && qa_acc.size() > abase) begin
        a_in_valid = 1'b0;
        a_in_data = {$urandom, $urandom};
      end
      if (!stalled && stall_at >= 0 && qa_data.size() == base + stall_at && a_out_valid) begin
        stalled = 1'b1;
        a_out_ready = 1'b0;
        sd = a_out_data;
        si = a_out_idx;
        sl = a_out_last;
        repeat (stall_len) begin
          @(negedge clk);
          if (a_out_data !== sd || a_out_idx !== si || a_out_last !== sl ||
              a_out_valid !== 1'b1 || qa_data.size() != base + stall_at) held_bad++;
        end
        a_out_ready = 1'b1;
      end
      if (guard > 100) begin
        timeout = 1;
        break;
      end
    end
    post_ready = a_in_ready;
  endtask

  task automatic collect_b(output int timeout);
    int base = qb_data.size();
    int abase = qb_acc.size();
    int guard = 0;
    timeout = 0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) b_in_data[i*8 +: 8] = 8'(vals[i]);
    b_in_valid = 1'b1;
    b_out_ready = 1'b1;
    while (qb_data.size() < base + 8) begin
      @(negedge clk);
      guard++;
      if (b_in_valid && qb_acc.size() > abase) begin
        b_in_valid = 1'b0;
        b_in_data = {$urandom, $urandom};
      end
      if (guard > 100) begin
        timeout = 1;
        break;
      end
    end
    post_ready = b_in_ready;
  endtask

  task automatic test_reset();
    int bad = 0;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_out_data, a_out_idx, a_out_last} !== 21'h10_0000) begin
      errors++;
      $display("FAIL reset_a: got rdy=%b vld=%b data=%h idx=%h last=%b want 1 0 0 0 0",
               a_in_ready, a_out_valid, a_out_data, a_out_idx, a_out_last);
    end
    checks++;
    if ({b_in_ready, b_out_valid, b_out_data, b_out_idx, b_out_last} !== 14'h2000) begin
      errors++;
      $display("FAIL reset_b: got rdy=%b vld=%b data=%h idx=%h last=%b want 1 0 0 0 0",
               b_in_ready, b_out_valid, b_out_data, b_out_idx, b_out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
          b_in_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_after_reset: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_basic();
    int to;
    int base = qa_data.size();
    vals[0] = 'h0010; vals[1] = 'h0300; vals[2] = 'h0005; vals[3] = 'hFFFF;
    model(4, 1'b1);
    collect_a(-1, 0, to);
    checks++;
    if (to != 0) begin
      errors++;
      $display("FAIL basic_timeout: got %0d want 0", to);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (qa_data[base+k] !== vals[ord[k]] || qa_idx[base+k] !== ord[k] ||
            qa_last[base+k] !== int'(k == 3)) begin
          errors++;
          $display("FAIL basic[%0d]: got %0h/%0d/%0d want %0h/%0d/%0d", k, qa_data[base+k],
                   qa_idx[base+k], qa_last[base+k], vals[ord[k]], ord[k], int'(k == 3));
        end
      end
    end
    checks++;
    if (post_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_after_last: got %b want 1", post_ready);
    end
  endtask

  task automatic test_ties_backpressure();
    int to;
    int base = qa_data.size();
    vals[0] = 7; vals[1] = 9; vals[2] = 7; vals[3] = 9;
    model(4, 1'b1);
    collect_a(1, 3, to);
    checks++;
    if (to != 0 || held_bad != 0) begin
      errors++;
      $display("FAIL ties_stall: got timeout=%0d held_bad=%0d want 0 0", to, held_bad);
    end
    if (to == 0) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (qa_data[base+k] !== vals[ord[k]] || qa_idx[base+k] !== ord[k] ||
            qa_last[base+k] !== int'(k == 3)) begin
          errors++;
          $display("FAIL ties[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", k, qa_data[base+k],
                   qa_idx[base+k], qa_last[base+k], vals[ord[k]], ord[k], int'(k == 3));
        end
      end
    end
  endtask

  task automatic test_ascend8();
    int to;
    int base = qb_data.size();
    vals[0] = 'h80; vals[1] = 'h00; vals[2] = 'hFF; vals[3] = 'h01;
    vals[4] = 'h7F; vals[5] = 'h00; vals[6] = 'h10; vals[7] = 'h02;
    model(8, 1'b0);
    collect_b(to);
    checks++;
    if (to != 0 || post_ready !== 1'b1) begin
      errors++;
      $display("FAIL ascend_done: got timeout=%0d ready=%b want 0 1", to, post_ready);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (qb_data[base+k] !== vals[ord[k]] || qb_idx[base+k] !== ord[k] ||
            qb_last[base+k] !== int'(k == 7)) begin
          errors++;
          $display("FAIL ascend[%0d]: got %0h/%0d/%0d want %0h/%0d/%0d", k, qb_data[base+k],
                   qb_idx[base+k], qb_last[base+k], vals[ord[k]], ord[k], int'(k == 7));
        end
      end
    end
  endtask

  task automatic test_random();
    int to, base, bad;
    for (int it = 0; it < 20; it++) begin
      bad = 0;
      base = qa_data.size();
      gen(4, 65535);
      model(4, 1'b1);
      collect_a(int'($urandom_range(0, 4)) - 1, int'($urandom_range(1, 3)), to);
      if (to != 0 || held_bad != 0) bad++;
      else for (int k = 0; k < 4; k++)
        if (qa_data[base+k] !== vals[ord[k]] || qa_idx[base+k] !== ord[k] ||
            qa_last[base+k] !== int'(k == 3)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_a[%0d]: got %0d bad items (timeout=%0d held=%0d) want 0",
                 it, bad, to, held_bad);
      end
      bad = 0;
      base = qb_data.size();
      gen(8, 255);
      model(8, 1'b0);
      collect_b(to);
      if (to != 0) bad++;
      else for (int k = 0; k < 8; k++)
        if (qb_data[base+k] !== vals[ord[k]] || qb_idx[base+k] !== ord[k] ||
            qb_last[base+k] !== int'(k == 7)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_b[%0d]: got %0d bad items (timeout=%0d) want 0", it, bad, to);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int to, base2;
    int guard = 0;
    int base = qa_data.size();
    int abase = qa_acc.size();
    @(negedge clk);
    a_in_data = {16'd1, 16'd2, 16'd3, 16'd4};
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    while (qa_data.size() < base + 2 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (qa_acc.size() > abase) a_in_valid = 1'b0;
    end
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || guard >= 50) begin
      errors++;
      $display("FAIL reset_mid: got vld=%b rdy=%b guard=%0d want 0 1 <50",
               a_out_valid, a_in_ready, guard);
    end
    @(negedge clk);
    rst_n = 1'b1;
    base2 = qa_data.size();
    vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
    model(4, 1'b1);
    collect_a(-1, 0, to);
    repeat (3) @(negedge clk);
    checks++;
    if (to != 0 || qa_data.size() != base2 + 4) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d outputs want 4", qa_data.size() - base2);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (qa_data[base2+k] !== vals[ord[k]] || qa_idx[base2+k] !== ord[k] ||
            qa_last[base2+k] !== int'(k == 3)) begin
          errors++;
          $display("FAIL reset_mid[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", k,
                   qa_data[base2+k], qa_idx[base2+k], qa_last[base2+k], vals[ord[k]], ord[k],
                   int'(k == 3));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int v1[4], o1[4];
    logic [63:0] d2;
    int guard = 0;
    int bad = 0;
    int base = qa_data.size();
    int abase = qa_acc.size();
    int lbase = qa_lcyc.size();
    gen(4, 65535);
    model(4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      v1[i] = vals[i];
      o1[i] = ord[i];
    end
    gen(4, 65535);
    model(4, 1'b1);
    for (int i = 0; i < 4; i++) d2[i*16 +: 16] = 16'(vals[i]);
    @(negedge clk);
    for (int i = 0; i < 4; i++) a_in_data[i*16 +: 16] = 16'(v1[i]);
    a_in_valid = 1'b1;
    a_out_ready = 1'b1;
    while (qa_data.size() < base + 8 && guard < 100) begin
      @(negedge clk);
      guard++;
      if (a_out_valid && a_out_last && qa_acc.size() == abase + 1) a_in_data = d2;
      if (qa_acc.size() >= abase + 2) a_in_valid = 1'b0;
    end
    a_in_valid = 1'b0;
    checks++;
    if (guard >= 100 || qa_acc.size() < abase + 2 || qa_lcyc.size() <= lbase) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d outputs want 8", qa_data.size() - base);
    end else begin
      checks++;
      if (qa_acc[abase+1] != qa_lcyc[lbase] + 1) begin
        errors++;
        $display("FAIL b2b_accept_cycle: got %0d want %0d", qa_acc[abase+1],
                 qa_lcyc[lbase] + 1);
      end
      checks++;
      if (qa_acc[abase+1] - qa_acc[abase] != 5) begin
        errors++;
        $display("FAIL b2b_throughput: got %0d cycles want 5", qa_acc[abase+1] - qa_acc[abase]);
      end
      for (int k = 0; k < 4; k++) begin
        if (qa_data[base+k] !== v1[o1[k]] || qa_idx[base+k] !== o1[k] ||
            qa_last[base+k] !== int'(k == 3)) bad++;
        if (qa_data[base+4+k] !== vals[ord[k]] || qa_idx[base+4+k] !== ord[k] ||
            qa_last[base+4+k] !== int'(k == 3)) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL b2b_data: got %0d bad items want 0", bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties_backpressure();
    test_ascend8();
    test_random();
    test_reset_mid_emit();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t want completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/seq_sort_extract.md
Name: seq_sort_extract

Overview:
- Parametrised sequential successor to the combinational 4-input descending sorter.
- Accepts one vector of N unsigned WIDTH-bit elements per transaction.
- Repeatedly selects the extreme remaining element, streams it out, and removes it from the working set, giving N → N-1 → … reduction over time instead of in a cascade of compare stages.
- Sits between the data-capture stage and downstream consumers; ready/valid on both sides.

Parameters:
- WIDTH, 16, element width in bits (≥1).
- N, 4, elements per vector (≥2).
- DESCEND, 1, 1 = largest first; 0 = smallest first.
- IDXW, $clog2(N), index width (derived; do not override).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  N*WIDTH  packed vector; element i = in_data[i*WIDTH +: WIDTH].
- out_valid  out  1  out_data/out_idx/out_last valid.
- out_ready  in  1  downstream accepts the current output.
- out_data  out  WIDTH  selected element value.
- out_idx  out  IDXW  original position of the selected element in in_data.
- out_last  out  1  high with the Nth (final) output of the vector.

Behaviour:
- Storage: buf[N] of WIDTH bits, live mask[N], emit count cnt (IDXW+1 bits), state {IDLE, EMIT}.
- Reset (rst_n low, asynchronous): state=IDLE, buf=0, mask=0, cnt=0.
  - Outputs during and after reset until the first accept: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: buf←in_data, mask←all 1, cnt←0, state→EMIT.
  - in_data is sampled only on that edge.
- EMIT:
  - in_ready=0; in_valid is ignored and must be held by the upstream.
  - out_valid=1.
  - Selection is combinational from the registered buf/mask: among elements with mask=1, pick the maximum (DESCEND=1) or minimum (DESCEND=0), unsigned compare.
  - Ties: the lowest original index wins (stable sort).
  - out_data=buf[sel], out_idx=sel, out_last=(cnt==N-1).
- Stall: while out_valid&!out_ready, buf/mask/cnt are unchanged, so out_data/out_idx/out_last are held stable.
- Transfer (out_valid&out_ready):
  - mask[sel]←0, cnt←cnt+1.
  - If out_last, state→IDLE and in_ready=1 on the following cycle.
- Latency and throughput:
  - First output is valid the cycle after input accept.
  - With out_ready held high, one element per cycle; N+1 cycles per vector.
  - No overlap of load and emit (in_ready is low for the whole of EMIT).
- Non-unique values: every element is emitted exactly once, including duplicates; the out_idx sequence is a permutation of 0..N-1.
- Reset mid-EMIT discards the vector. The next vector is accepted with a fresh mask; no stale elements are emitted.
- Unsigned arithmetic only. 0 and 2^WIDTH-1 must order correctly. No sign extension anywhere.
- The N-way selection may be a linear scan or a reduction tree; combinational depth is an implementation choice, but the tie rule must hold.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle → in_ready=1, out_valid=0, out_data=0 immediately.
  - No out_valid for 10 cycles with in_valid=0.
- Basic descend, N=4, W=16, in={e0=0x0010, e1=0x0300, e2=0x0005, e3=0xFFFF}, out_ready=1:
  - Required outputs (data/idx): 0xFFFF/3, 0x0300/1, 0x0010/0, 0x0005/2.
  - out_last only on the 4th; in_ready high the next cycle.
- Ties and backpressure, in={7,9,7,9}:
  - Required order (data/idx): 9/1, 9/3, 7/0, 7/2.
  - Drop out_ready for 3 cycles on the 2nd output → outputs held constant, mask not advanced.
- DESCEND=0, N=8, W=8, in={0x80,0x00,0xFF,0x01,0x7F,0x00,0x10,0x02}:
  - Required order: 0x00/1, 0x00/5, 0x01/3, 0x02/7, 0x10/6, 0x7F/4, 0x80/0, 0xFF/2.
- Reset mid-EMIT: accept {4,3,2,1}, take 2 outputs, pulse rst_n low, then accept {1,2,3,4}:
  - Required outputs: 4/3, 3/2, 2/1, 1/0. None of the old elements may appear.
- Back-to-back with in_valid held continuously:
  - Second vector is accepted exactly in the cycle after the first out_last transfer.
  - Throughput is 5 cycles per vector for N=4.
